maze_generator: RTL and testbench

Produces the 625-bit maze image and `load` strobe that the player controller consumes. On a `start` pulse it carves a perfect maze (single path between any two cells) into a 25x25 grid by randomized depth-first search. The search uses an explicit cell stack and a seeded 16-bit LFSR. It sits between the game-level FSM, which supplies `start`/`seed`, and the player controller, which latches `maze` on `load`.

---
 rtl/maze_generator.sv | 117 +++++++++++
 tb/tb_maze_generator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/maze_generator.sv
// Randomized depth-first maze carver: a 25x25 PATH/WALL image built with an
// explicit cell stack and a 16-bit LFSR, presented with a load strobe.
module maze_generator #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [15:0]  seed,
  output logic [624:0] maze,
  output logic         load,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, INIT, CHECK, CARVE, POP, DONE} state_t;

  localparam logic [624:0] FIRST_CELL = 625'(1) << 26;

  state_t       state;
  logic [143:0] visited;
  logic [7:0]   stack [144];
  logic [7:0]   sp;
  logic [15:0]  lfsr;

  logic [7:0]   top, ci, cj, nbr;
  logic [3:0]   avail;
  logic [1:0]   dir;
  logic [9:0]   cell_bit, wall_bit, nbr_bit;
  logic         lfsr_fb;

  // First available direction scanning r, r+1, r+2, r+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] a, input logic [1:0] r);
    logic [1:0] d;
    pick = r;
    for (int k = 3; k >= 0; k--) begin
      d = r + 2'(k);
      if (a[d]) pick = d;
    end
  endfunction

  always_comb begin
    top      = (sp != 8'd0) ? stack[sp - 8'd1] : 8'd0;
    ci       = top % 8'd12;
    cj       = top / 8'd12;
    avail[0] = (cj != 8'd0)  && !visited[top - 8'd12];
    avail[1] = (ci != 8'd11) && !visited[top + 8'd1];
    avail[2] = (cj != 8'd11) && !visited[top + 8'd12];
    avail[3] = (ci != 8'd0)  && !visited[top - 8'd1];
    dir      = pick(avail, lfsr[1:0]);
    cell_bit = 10'(cj) * 10'd50 + 10'(ci) * 10'd2 + 10'd26;
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    case (dir)
      2'd0:    begin wall_bit = cell_bit - 10'd25; nbr_bit = cell_bit - 10'd50; nbr = top - 8'd12; end
      2'd1:    begin wall_bit = cell_bit + 10'd1;  nbr_bit = cell_bit + 10'd2;  nbr = top + 8'd1;  end
      2'd2:    begin wall_bit = cell_bit + 10'd25; nbr_bit = cell_bit + 10'd50; nbr = top + 8'd12; end
      default: begin wall_bit = cell_bit - 10'd1;  nbr_bit = cell_bit - 10'd2;  nbr = top - 8'd1;  end
    endcase
  end

  // The start edge itself clears the image and seeds the search, so the
  // previous maze is gone right after a restart is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      maze    <= '0;
      load    <= 1'b0;
      busy    <= 1'b0;
      sp      <= 8'd0;
      visited <= '0;
      lfsr    <= DEFAULT_SEED;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state   <= INIT;
          maze    <= FIRST_CELL;
          visited <= 144'd1;
          sp      <= 8'd1;
          lfsr    <= (seed == 16'd0) ? DEFAULT_SEED : seed;
          busy    <= 1'b1;
          load    <= 1'b0;
        end
        INIT: state <= CHECK;
        // An emptied stack is noticed here, which fixes the total at 576 cycles.
        CHECK: begin
          if (sp == 8'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            load  <= 1'b1;
          end else if (|avail) begin
            state <= CARVE;
          end else begin
            state <= POP;
          end
        end
        CARVE: begin
          maze[wall_bit] <= 1'b1;
          maze[nbr_bit]  <= 1'b1;
          visited[nbr]   <= 1'b1;
          sp             <= sp + 8'd1;
          lfsr           <= {lfsr[14:0], lfsr_fb};
          state          <= CHECK;
        end
        POP: begin
          sp    <= sp - 8'd1;
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE || state == DONE) && start) stack[0] <= 8'd0;
    else if (state == CARVE)                       stack[sp] <= nbr;
  end

endmodule

// File: tb/tb_maze_generator.sv
// Directed bench for maze_generator: timing, maze structure, determinism,
// ignored starts, mid-run reset and restart from DONE.
module tb_maze_generator;

  logic         clk, resetn, start;
  logic [15:0]  seed;
  logic [624:0] maze;
  logic         load, busy;

  int n_asrt = 0;
  int n_fail = 0;

  localparam logic [624:0] M26 = 625'(1) << 26;

  maze_generator dut (
    .clk(clk), .resetn(resetn), .start(start), .seed(seed),
    .maze(maze), .load(load), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_maze(input string tag, input logic [624:0] obs, input logic [624:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent behavioural DFS used as the golden image for a seed.
  function automatic logic [624:0] model(input logic [15:0] s);
    int dxs [4] = '{0, 1, 0, -1};
    int dys [4] = '{-1, 0, 1, 0};
    bit vis [144];
    int stk [144];
    int sp;
    logic [15:0] l;
    logic [624:0] m;
    l = (s == 16'd0) ? 16'hACE1 : s;
    m = M26;
    foreach (vis[i]) vis[i] = 0;
    vis[0] = 1; stk[0] = 0; sp = 1;
    while (sp > 0) begin
      int c, x, y, d, nx, ny, dd;
      c = stk[sp-1]; x = c % 12; y = c / 12; d = -1;
      for (int k = 0; k < 4; k++) begin
        dd = (int'(l[1:0]) + k) % 4;
        nx = x + dxs[dd]; ny = y + dys[dd];
        if (d < 0 && nx >= 0 && nx < 12 && ny >= 0 && ny < 12 && !vis[ny*12+nx]) d = dd;
      end
      if (d < 0) sp--;
      else begin
        nx = x + dxs[d]; ny = y + dys[d];
        m[(2*y+1+dys[d])*25 + 2*x+1+dxs[d]] = 1'b1;
        m[(2*ny+1)*25 + 2*nx+1] = 1'b1;
        vis[ny*12+nx] = 1;
        stk[sp] = ny*12+nx; sp++;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
    end
    return m;
  endfunction

  task automatic check_struct(input string tag, input logic [624:0] m);
    int ones, border, cells, evens, reached, p, x, y;
    bit [624:0] seen;
    int q [$];
    ones = 0; border = 0; cells = 0; evens = 0; reached = 0; seen = '0;
    for (int yy = 0; yy < 25; yy++)
      for (int xx = 0; xx < 25; xx++)
        if (m[yy*25+xx]) begin
          ones++;
          if (yy == 0 || yy == 24 || xx == 0 || xx == 24) border++;
          if (yy % 2 == 1 && xx % 2 == 1) cells++;
          if (yy % 2 == 0 && xx % 2 == 0) evens++;
        end
    if (m[26]) begin seen[26] = 1'b1; q.push_back(26); end
    while (q.size() > 0) begin
      p = q.pop_front(); x = p % 25; y = p / 25;
      if (x % 2 == 1 && y % 2 == 1) reached++;
      if (x > 0  && m[p-1]  && !seen[p-1])  begin seen[p-1]  = 1'b1; q.push_back(p-1);  end
      if (x < 24 && m[p+1]  && !seen[p+1])  begin seen[p+1]  = 1'b1; q.push_back(p+1);  end
      if (y > 0  && m[p-25] && !seen[p-25]) begin seen[p-25] = 1'b1; q.push_back(p-25); end
      if (y < 24 && m[p+25] && !seen[p+25]) begin seen[p+25] = 1'b1; q.push_back(p+25); end
    end
    chk({tag, "_ones"}, ones, 287);
    chk({tag, "_border"}, border, 0);
    chk({tag, "_bit26"}, int'(m[26]), 1);
    chk({tag, "_cells"}, cells, 144);
    chk({tag, "_even_even"}, evens, 0);
    chk({tag, "_reached"}, reached, 144);
  endtask

  // Start at a negedge so the next posedge is the start edge E.
  task automatic gen(input logic [15:0] s, input bit disturb, output logic [624:0] img);
    int lat;
    bit busy_drop;
    @(negedge clk); seed = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    chk("load_fall", int'(load), 0);
    chk_maze("start_image", maze, M26);
    lat = 0; busy_drop = 0;
    while (!load && lat < 700) begin
      @(posedge clk); lat++; #1;
      if (disturb && (lat == 10 || lat == 300)) begin start = 1'b1; seed = 16'h5A5A; end
      else start = 1'b0;
      if (!load && !busy) busy_drop = 1;
    end
    start = 1'b0;
    chk("latency", lat, 576);
    chk("busy_fall", int'(busy), 0);
    chk("busy_held", int'(busy_drop), 0);
    img = maze;
  endtask

  initial begin
    logic [624:0] g1234, img, a, b;
    bit bad;
    clk = 1'b0; resetn = 1'b0; start = 1'b0; seed = 16'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_maze("reset_maze", maze, '0);
    chk("reset_load", int'(load), 0);
    chk("reset_busy", int'(busy), 0);
    resetn = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (maze != '0 || load || busy) bad = 1;
    end
    chk("idle_quiet", int'(bad), 0);

    gen(16'h1234, 1'b0, g1234);
    chk_maze("model_1234", g1234, model(16'h1234));
    check_struct("s1234", g1234);
    // Seed 0x1234: r=0, UP is off-grid, so the first carve goes RIGHT.
    chk("first_carve_right", int'(g1234[27]), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_load_held", int'(load), 1);
    chk_maze("done_image_held", maze, g1234);

    gen(16'h1234, 1'b0, img);
    chk_maze("restart_same_seed", img, g1234);

    gen(16'h0000, 1'b0, a);
    gen(16'hACE1, 1'b0, b);
    chk_maze("seed0_vs_default", a, b);
    chk_maze("model_seed0", a, model(16'h0000));
    check_struct("s0", a);

    gen(16'h8001, 1'b0, img);
    chk("seed_8001_differs", int'(img !== g1234), 1);
    check_struct("s8001", img);

    gen(16'h1234, 1'b1, img);
    chk_maze("start_while_busy", img, g1234);

    @(negedge clk); seed = 16'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (199) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk_maze("midrun_reset_maze", maze, '0);
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_load", int'(load), 0);
    @(negedge clk); resetn = 1'b1;
    gen(16'h1234, 1'b0, img);
    chk_maze("after_reset_golden", img, g1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
